mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mul_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end that shares one multi-cycle multiplier
// between two requesters. A grant latches the winner's operands, pulses
// start, waits for done (bounded by TIMEOUT cycles), then either acks the
// requester with the captured product or aborts with timeout_err. Every
// strobe is a flop output, so none of them can glitch on a state change.
module mul_arbiter #(
    parameter int WIDTH   = 64,
    parameter int TIMEOUT = 100
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 mul_op_start,
    output logic                 mul_op_clear,
    output logic [WIDTH-1:0]     mul_multiplicand,
    output logic [WIDTH-1:0]     mul_multiplier,
    input  logic                 mul_op_done,
    input  logic [2*WIDTH-1:0]   mul_result,
    output logic                 ack0,
    output logic                 ack1,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 grant_id,
    output logic                 timeout_err
);

    // One spare bit above what TIMEOUT-1 needs, so the saturation value can
    // never equal the abort threshold.
    localparam int                CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic                 rr_r;          // requester preferred on a tie
    logic                 rr_s;
    logic                 grant_id_r;
    logic                 grant_id_s;
    logic                 grant_s;       // a grant is being made this cycle
    logic                 capture_s;     // product is being captured this cycle
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_s;
    logic [WIDTH-1:0]     opa_r;
    logic [WIDTH-1:0]     opb_r;
    logic [2*WIDTH-1:0]   result_r;
    logic                 start_r;
    logic                 clear_r;
    logic                 ack0_r;
    logic                 ack1_r;
    logic                 err_r;
    logic                 busy_r;

    // Next-state, arbitration and WAIT-counter logic
    always_comb begin
        state_s    = state_r;
        rr_s       = rr_r;
        grant_id_s = grant_id_r;
        grant_s    = 1'b0;
        capture_s  = 1'b0;
        cnt_s      = cnt_r;
        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    grant_s = 1'b1;
                    if (req0 && req1) begin
                        grant_id_s = rr_r;
                    end else if (req0) begin
                        grant_id_s = 1'b0;
                    end else begin
                        grant_id_s = 1'b1;
                    end
                    rr_s    = ~grant_id_s;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                cnt_s   = CNT_ZERO;
                state_s = WAIT;
            end
            WAIT: begin
                // done is tested first so it wins over a simultaneous timeout
                if (mul_op_done) begin
                    capture_s = 1'b1;
                    state_s   = DONE;
                end else if (cnt_r == CNT_LIMIT) begin
                    state_s = ABORT;
                end else begin
                    state_s = WAIT;
                end
                if (cnt_r != CNT_MAX) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            ABORT: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control registers; strobes are decoded from the next state so they are
    // aligned with the state they belong to and come straight from flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            rr_r       <= 1'b0;
            grant_id_r <= 1'b0;
            cnt_r      <= CNT_ZERO;
            start_r    <= 1'b0;
            clear_r    <= 1'b0;
            ack0_r     <= 1'b0;
            ack1_r     <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            rr_r       <= rr_s;
            grant_id_r <= grant_id_s;
            cnt_r      <= cnt_s;
            start_r    <= (state_s == START);
            clear_r    <= (state_s == DONE) || (state_s == ABORT);
            ack0_r     <= (state_s == DONE) && (grant_id_s == 1'b0);
            ack1_r     <= (state_s == DONE) && (grant_id_s == 1'b1);
            err_r      <= (state_s == ABORT);
            busy_r     <= (state_s != IDLE);
        end
    end

    // Datapath: operands frozen at grant, product captured only on done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_r    <= {WIDTH{1'b0}};
            opb_r    <= {WIDTH{1'b0}};
            result_r <= {(2*WIDTH){1'b0}};
        end else begin
            if (grant_s) begin
                opa_r <= grant_id_s ? a1 : a0;
                opb_r <= grant_id_s ? b1 : b0;
            end else begin
                opa_r <= opa_r;
                opb_r <= opb_r;
            end
            if (capture_s) begin
                result_r <= mul_result;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign mul_op_start     = start_r;
    assign mul_op_clear     = clear_r;
    assign mul_multiplicand = opa_r;
    assign mul_multiplier   = opb_r;
    assign ack0             = ack0_r;
    assign ack1             = ack1_r;
    assign result           = result_r;
    assign busy             = busy_r;
    assign grant_id         = grant_id_r;
    assign timeout_err      = err_r;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: drives jobs into mul_arbiter with a behavioural multiplier
// of programmable latency and checks each job against transaction-level
// expectations (who is granted, when the job ends, how it ends, what result).
module tb_mul_arbiter;

    localparam int W  = 64;
    localparam int TO = 100;

    typedef logic [2*W-1:0] word2_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req0, req1;
    logic [W-1:0]     a0, b0, a1, b1;
    logic             mul_op_start, mul_op_clear, mul_op_done;
    logic [W-1:0]     mul_multiplicand, mul_multiplier;
    logic [2*W-1:0]   mul_result, result;
    logic             ack0, ack1, busy, grant_id, timeout_err;

    int     checks   = 0;
    int     failures = 0;
    word2_t exp_result = '0;
    int     mul_lat = 0;

    always #5 clk = ~clk;

    mul_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .mul_op_start(mul_op_start), .mul_op_clear(mul_op_clear),
        .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
        .mul_op_done(mul_op_done), .mul_result(mul_result),
        .ack0(ack0), .ack1(ack1), .result(result), .busy(busy),
        .grant_id(grant_id), .timeout_err(timeout_err)
    );

    // Behavioural multiplier: done rises mul_lat cycles into the wait and
    // stays up until cleared
    logic   mul_active;
    int     mul_cnt;
    word2_t mul_prod;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_active <= 1'b0;
            mul_cnt    <= 0;
            mul_prod   <= '0;
        end else if (mul_op_clear) begin
            mul_active <= 1'b0;
        end else if (mul_op_start) begin
            mul_active <= 1'b1;
            mul_cnt    <= 0;
            mul_prod   <= {{W{1'b0}}, mul_multiplicand} * {{W{1'b0}}, mul_multiplier};
        end else if (mul_active) begin
            mul_cnt <= mul_cnt + 1;
        end
    end
    assign mul_op_done = mul_active && (mul_cnt >= mul_lat);
    assign mul_result  = mul_prod;

    task automatic check_eq(input string tag, input word2_t got, input word2_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    function automatic word2_t ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
        return word2_t'(a) * word2_t'(b);
    endfunction

    // One job from a single requester; called on a falling edge
    task automatic run_job(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int lat, input bit drop_mid);
        int  k;
        int  starts;
        bit  stable;
        bit  done_ok;
        word2_t prod;
        prod    = ref_product(a, b);
        done_ok = (lat < TO);
        mul_lat = lat;
        if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
        else    begin a0 = a; b0 = b; req0 = 1'b1; end
        k = 0;
        @(negedge clk);
        while (!mul_op_start && k < 5) begin @(negedge clk); k++; end
        check_eq("start_pulse", word2_t'(mul_op_start), word2_t'(1));
        check_eq("grant_id", word2_t'(grant_id), word2_t'(id));
        check_eq("latched_a", word2_t'(mul_multiplicand), word2_t'(a));
        check_eq("latched_b", word2_t'(mul_multiplier), word2_t'(b));
        stable = 1'b1;
        starts = 0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            a0 = rand_word(); b0 = rand_word(); a1 = rand_word(); b1 = rand_word();
            if (drop_mid && k == 1) begin req0 = 1'b0; req1 = 1'b0; end
            if (mul_multiplicand !== a || mul_multiplier !== b) stable = 1'b0;
            if (mul_op_start) starts++;
        end while (!(ack0 || ack1 || timeout_err) && k < TO + 10);
        check_eq("end_cycle", word2_t'(k), word2_t'(done_ok ? lat + 2 : TO + 1));
        check_eq("ack_id", word2_t'({ack1, ack0}),
                 word2_t'(done_ok ? (id ? 2'b10 : 2'b01) : 2'b00));
        check_eq("timeout_err", word2_t'(timeout_err), word2_t'(!done_ok));
        check_eq("op_clear", word2_t'(mul_op_clear), word2_t'(1));
        check_eq("operands_stable", word2_t'(stable), word2_t'(1));
        check_eq("extra_start", word2_t'(starts), word2_t'(0));
        if (done_ok) exp_result = prod;
        check_eq("result", result, exp_result);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check_eq("busy_low", word2_t'(busy), word2_t'(0));
        check_eq("strobes_one_cycle", word2_t'({mul_op_clear, ack1, ack0, timeout_err}), word2_t'(0));
    endtask

    // Both requesters held high from reset: grants alternate 0,1,0 with the
    // minimum two idle-side cycles between jobs
    task automatic run_contention();
        int k;
        int seen;
        int last_start;
        bit cur_id;
        bit exp_id;
        logic [W-1:0] ca0, cb0, ca1, cb1;
        ca0 = rand_word(); cb0 = rand_word(); ca1 = rand_word(); cb1 = rand_word();
        a0 = ca0; b0 = cb0; a1 = ca1; b1 = cb1;
        mul_lat = 3;
        req0 = 1'b1;
        req1 = 1'b1;
        seen = 0; k = 0; last_start = 0; cur_id = 1'b0;
        while (seen < 3 && k < 60) begin
            @(negedge clk);
            k++;
            if (ack0 || ack1) begin
                check_eq("rr_ack", word2_t'({ack1, ack0}), word2_t'(cur_id ? 2'b10 : 2'b01));
            end
            if (mul_op_start) begin
                exp_id = (seen == 1);
                if (seen > 0) check_eq("b2b_gap", word2_t'(k - last_start), word2_t'(3 + 4));
                check_eq("rr_grant", word2_t'(grant_id), word2_t'(exp_id));
                check_eq("rr_operand", word2_t'(mul_multiplicand), word2_t'(exp_id ? ca1 : ca0));
                cur_id = exp_id;
                last_start = k;
                seen++;
            end
        end
        check_eq("contention_jobs", word2_t'(seen), word2_t'(3));
        req0 = 1'b0;
        req1 = 1'b0;
        k = 0;
        while (!(ack0 || ack1 || timeout_err) && k < 20) begin @(negedge clk); k++; end
        check_eq("third_ack", word2_t'({ack1, ack0}), word2_t'(2'b01));
        exp_result = ref_product(ca0, cb0);
        check_eq("third_result", result, exp_result);
        @(negedge clk);
    endtask

    // Reset pulse 30 cycles into a wait: everything drops at once and the
    // abandoned job never completes
    task automatic run_reset_mid_wait();
        int k;
        int stray;
        a0 = rand_word(); b0 = rand_word();
        mul_lat = 200;
        req0 = 1'b1;
        k = 0;
        @(negedge clk);
        while (!mul_op_start && k < 5) begin @(negedge clk); k++; end
        check_eq("rst_job_start", word2_t'(mul_op_start), word2_t'(1));
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("rst_strobes", word2_t'({busy, mul_op_start, mul_op_clear, ack0, ack1, timeout_err}),
                 word2_t'(0));
        check_eq("rst_result", result, word2_t'(0));
        check_eq("rst_grant_ops", word2_t'({grant_id, mul_multiplicand, mul_multiplier}), word2_t'(0));
        req0 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_result = '0;
        stray = 0;
        repeat (TO + 20) begin
            @(negedge clk);
            if (ack0 || ack1 || timeout_err || mul_op_clear || busy) stray++;
        end
        check_eq("rst_no_stray", word2_t'(stray), word2_t'(0));
        run_job(1'b1, rand_word(), rand_word(), 10, 1'b0);
    endtask

    initial begin
        int r;
        int lat;
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #2;
        check_eq("reset_outputs", word2_t'({busy, mul_op_start, mul_op_clear, ack0, ack1, timeout_err, grant_id}),
                 word2_t'(0));
        check_eq("reset_result", result, word2_t'(0));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("idle_after_reset", word2_t'(busy), word2_t'(0));

        run_contention();
        run_job(1'b0, 64'd3, 64'd5, 65, 1'b0);
        check_eq("single_job_15", result, word2_t'(15));
        run_job(1'b1, rand_word(), rand_word(), TO, 1'b0);
        check_eq("timeout_keeps_result", result, word2_t'(15));
        run_job(1'b0, rand_word(), rand_word(), TO - 1, 1'b0);
        run_job(1'b0, {W{1'b1}}, {W{1'b1}}, 20, 1'b0);
        run_job(1'b1, rand_word(), rand_word(), 5, 1'b1);
        run_job(1'b0, rand_word(), rand_word(), 0, 1'b0);
        run_reset_mid_wait();

        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       lat = $urandom_range(0, 30);
            else if (r == 6) lat = TO - 1;
            else if (r == 7) lat = TO;
            else             lat = $urandom_range(TO - 3, TO + 5);
            run_job(1'($urandom_range(0, 1)), rand_word(), rand_word(), lat,
                    1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
